// File: rtl/sop_sweep_pkg.sv
// Shared types and constants for the sum-of-products sweep controller.
package sop_sweep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } sweep_state_t;

   // Truth table of y = ~b & (~c | a), indexed by {a,b,c}
   localparam logic [7:0] EXP_MASK = 8'h31;
   localparam int unsigned N_VEC   = 8;

endpackage

// File: rtl/sop_sweep_ctrl_if.sv
// Stimulus/result bundle between the sweep controller and its environment.
interface sop_sweep_ctrl_if;
   logic       start;
   logic       y_in;
   logic [2:0] abc;
   logic       busy;
   logic       done;
   logic [3:0] err_count;
   logic [7:0] fail_mask;
   logic       pass;

   modport master (
      output start, y_in,
      input  abc, busy, done, err_count, fail_mask, pass
   );

   modport slave (
      input  start, y_in,
      output abc, busy, done, err_count, fail_mask, pass
   );
endinterface

// File: rtl/settle_counter.sv
// 8-bit down-counter timing how long each vector is held before sampling.
module settle_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [7:0] i_load_val,
   output logic       o_zero
);
   logic [7:0] r_count;

   // Count register: load has priority, then decrement, parking at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 8'd0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != 8'd0)) begin
         r_count <= r_count - 8'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_zero = (r_count == 8'd0);
endmodule

// File: rtl/sop_sweep_ctrl.sv
// Clocked sweep of all 8 {a,b,c} vectors into the SOP gate block, scoring y against its truth table.
module sop_sweep_ctrl
   import sop_sweep_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   sop_sweep_ctrl_if.slave  bus
);
   localparam logic [7:0] LOAD_VAL = 8'(SETTLE_CYCLES - 1);
   localparam logic [2:0] LAST_VEC = 3'(N_VEC - 1);

   sweep_state_t r_state;
   sweep_state_t w_state_nxt;
   logic [2:0]   r_abc;
   logic [2:0]   w_abc_nxt;
   logic [3:0]   r_err;
   logic [3:0]   w_err_nxt;
   logic [7:0]   r_mask;
   logic [7:0]   w_mask_nxt;
   logic         r_busy;
   logic         w_busy_nxt;
   logic         r_done;
   logic         w_done_nxt;
   logic         r_y_smp;
   logic         w_cnt_zero;
   logic         w_cnt_load;
   logic         w_cnt_en;
   logic         w_last;
   logic         w_miss;

   assign w_last = (r_abc == LAST_VEC);
   assign w_miss = (r_y_smp != EXP_MASK[r_abc]);

   // The counter is reloaded on every entry into SETTLE and runs only there
   assign w_cnt_load = (w_state_nxt == ST_SETTLE) && (r_state != ST_SETTLE);
   assign w_cnt_en   = (r_state == ST_SETTLE);

   settle_counter u_settle (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_load     (w_cnt_load),
      .i_en       (w_cnt_en),
      .i_load_val (LOAD_VAL),
      .o_zero     (w_cnt_zero)
   );

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; start is only honoured when not busy
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_state_nxt = ST_SETTLE;
            end else begin
               w_state_nxt = r_state;
            end
         end
         ST_SETTLE: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SAMPLE: begin
            if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_SETTLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Next values of the vector register and scoreboard
   always_comb begin
      w_abc_nxt  = r_abc;
      w_err_nxt  = r_err;
      w_mask_nxt = r_mask;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_abc_nxt  = 3'd0;
               w_err_nxt  = 4'd0;
               w_mask_nxt = 8'h00;
            end else begin
               w_abc_nxt  = r_abc;
            end
         end
         ST_SETTLE: begin
            w_abc_nxt = r_abc;
         end
         ST_SAMPLE: begin
            if (w_miss) begin
               w_err_nxt  = (r_err < 4'd8) ? (r_err + 4'd1) : r_err;
               w_mask_nxt = r_mask | (8'd1 << r_abc);
            end else begin
               w_err_nxt  = r_err;
            end
            if (w_last) begin
               w_abc_nxt = r_abc;
            end else begin
               w_abc_nxt = r_abc + 3'd1;
            end
         end
         default: begin
            w_abc_nxt  = 3'd0;
            w_err_nxt  = 4'd0;
            w_mask_nxt = 8'h00;
         end
      endcase
      w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_SAMPLE);
      w_done_nxt = (w_state_nxt == ST_DONE);
   end

   // Output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_abc  <= 3'd0;
         r_err  <= 4'd0;
         r_mask <= 8'h00;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_abc  <= w_abc_nxt;
         r_err  <= w_err_nxt;
         r_mask <= w_mask_nxt;
         r_busy <= w_busy_nxt;
         r_done <= w_done_nxt;
      end
   end

   // y is captured on the edge leaving SETTLE, SETTLE_CYCLES after abc moved
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_y_smp <= 1'b0;
      end else if ((r_state == ST_SETTLE) && w_cnt_zero) begin
         r_y_smp <= bus.y_in;
      end else begin
         r_y_smp <= r_y_smp;
      end
   end

   assign bus.abc       = r_abc;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.err_count = r_err;
   assign bus.fail_mask = r_mask;
   assign bus.pass      = r_done && (r_err == 4'd0);
endmodule
